ad9958_write_scheduler: RTL and testbench

Register-write scheduler that sits in front of the four-bit SPI shifter driving the AD9958. It arbitrates round-robin between two requesters, such as the host register path and the sweep engine. It also keeps the device channel-select register (CSR) consistent with each request by inserting a CSR write whenever the target channel changes. For each transaction it builds the nibble-packed frame, triggers the shifter, tracks its busy handshake and optionally pulses IO_UPDATE.

---
 rtl/ad9958_write_scheduler_if.sv | 42 ++++
 rtl/ad9958_write_scheduler.sv | 155 +++++++++++++++
 tb/tb_ad9958_write_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9958_write_scheduler_if.sv
// Request/SPI bundle between the write scheduler and its environment.
// master = requesters plus shifter side; slave = the scheduler.
interface ad9958_write_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_chan;
    logic [4:0]  req0_addr;
    logic [1:0]  req0_len;
    logic [31:0] req0_data;
    logic        req0_update;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_chan;
    logic [4:0]  req1_addr;
    logic [1:0]  req1_len;
    logic [31:0] req1_data;
    logic        req1_update;
    logic        spi_trigger;
    logic [63:0] spi_data;
    logic [4:0]  spi_packs;
    logic        spi_busy;
    logic        io_update;
    logic        busy;
    logic        done;
    logic        grant_id;

    modport master (
        output req0_valid, req0_chan, req0_addr, req0_len, req0_data, req0_update,
        output req1_valid, req1_chan, req1_addr, req1_len, req1_data, req1_update,
        output spi_busy,
        input  req0_ready, req1_ready, spi_trigger, spi_data, spi_packs,
        input  io_update, busy, done, grant_id
    );

    modport slave (
        input  req0_valid, req0_chan, req0_addr, req0_len, req0_data, req0_update,
        input  req1_valid, req1_chan, req1_addr, req1_len, req1_data, req1_update,
        input  spi_busy,
        output req0_ready, req1_ready, spi_trigger, spi_data, spi_packs,
        output io_update, busy, done, grant_id
    );
endinterface

// File: rtl/ad9958_write_scheduler.sv
// AD9958 register-write scheduler: round-robin arbitration between two
// requesters, CSR insertion on channel change, nibble-packed frame build,
// shifter busy handshake and optional IO_UPDATE pulse.
module ad9958_write_scheduler #(
    parameter int         UPDATE_WIDTH  = 4,
    parameter logic [2:0] CSR_MODE_BITS = 3'b110
) (
    input logic                      clock,
    input logic                      reset,
    ad9958_write_scheduler_if.slave  bus
);
    localparam int            UW       = $clog2(UPDATE_WIDTH + 1);
    localparam logic [UW-1:0] UPD_LAST = UW'(UPDATE_WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE, GRANT, CSR_TRIG, CSR_WHI, CSR_WLO,
        REG_TRIG, REG_WHI, REG_WLO, UPDATE, DONE
    } state_t;

    state_t        state, state_nxt;
    logic          last_gnt;
    logic          any_vld, win, chan_miss;
    logic [1:0]    win_chan;
    logic [1:0]    cache_chan;
    logic          cache_vld;
    logic [1:0]    cap_chan;
    logic [4:0]    cap_addr;
    logic [1:0]    cap_len;
    logic [31:0]   cap_data;
    logic          cap_upd;
    logic          gnt_id;
    logic [63:0]   frame;
    logic [4:0]    packs;
    logic [UW-1:0] upd_cnt;

    // Frame bytes go out high nibble first, so each byte lands nibble-swapped
    // in its byte lane of spi_data; byte 0 is the instruction.
    function automatic logic [63:0] reg_frame(input logic [4:0] addr,
                                              input logic [1:0] len,
                                              input logic [31:0] data);
        logic [63:0] f;
        logic [31:0] sh;
        int          nb;
        nb = (len == 2'd0) ? 4 : int'(len);
        f  = '0;
        f[7:0] = {addr[3:0], 3'b000, addr[4]};
        for (int j = 0; j < 4; j++) begin
            if (j < nb) begin
                sh = data >> (8 * (nb - 1 - j));
                f[8*j+8 +: 8] = {sh[3:0], sh[7:4]};
            end
        end
        return f;
    endfunction

    function automatic logic [4:0] reg_packs(input logic [1:0] len);
        return (len == 2'd0) ? 5'd10 : ({2'b00, len, 1'b0} + 5'd2);
    endfunction

    function automatic logic [63:0] csr_frame(input logic [1:0] chan);
        return {48'h0, 1'b0, CSR_MODE_BITS, chan, 2'b00, 8'h00};
    endfunction

    // Round-robin: with both pending, the one not granted last wins.
    assign any_vld   = bus.req0_valid | bus.req1_valid;
    assign win       = (bus.req0_valid && bus.req1_valid) ? ~last_gnt : bus.req1_valid;
    assign win_chan  = win ? bus.req1_chan : bus.req0_chan;
    assign chan_miss = !cache_vld || (cache_chan != win_chan);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_vld) state_nxt = GRANT;
            GRANT:    if (!any_vld)      state_nxt = IDLE;
                      else if (chan_miss) state_nxt = CSR_TRIG;
                      else               state_nxt = REG_TRIG;
            CSR_TRIG: state_nxt = CSR_WHI;
            CSR_WHI:  if (bus.spi_busy)  state_nxt = CSR_WLO;
            CSR_WLO:  if (!bus.spi_busy) state_nxt = REG_TRIG;
            REG_TRIG: state_nxt = REG_WHI;
            REG_WHI:  if (bus.spi_busy)  state_nxt = REG_WLO;
            REG_WLO:  if (!bus.spi_busy) state_nxt = cap_upd ? UPDATE : DONE;
            UPDATE:   if (upd_cnt == UPD_LAST) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from state so reset kills them asynchronously.
    assign bus.req0_ready  = (state == GRANT) && any_vld && !win;
    assign bus.req1_ready  = (state == GRANT) && any_vld &&  win;
    assign bus.spi_trigger = (state == CSR_TRIG) || (state == REG_TRIG);
    assign bus.io_update   = (state == UPDATE);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.spi_data    = frame;
    assign bus.spi_packs   = packs;
    assign bus.grant_id    = gnt_id;

    // Request capture, channel cache, frame registers and IO_UPDATE timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt   <= 1'b1;
            gnt_id     <= 1'b0;
            cache_vld  <= 1'b0;
            cache_chan <= '0;
            cap_chan   <= '0;
            cap_addr   <= '0;
            cap_len    <= '0;
            cap_data   <= '0;
            cap_upd    <= 1'b0;
            frame      <= '0;
            packs      <= '0;
            upd_cnt    <= '0;
        end else begin
            case (state)
                GRANT: if (any_vld) begin
                    last_gnt <= win;
                    gnt_id   <= win;
                    cap_chan <= win_chan;
                    cap_addr <= win ? bus.req1_addr   : bus.req0_addr;
                    cap_len  <= win ? bus.req1_len    : bus.req0_len;
                    cap_data <= win ? bus.req1_data   : bus.req0_data;
                    cap_upd  <= win ? bus.req1_update : bus.req0_update;
                    if (chan_miss) begin
                        frame <= csr_frame(win_chan);
                        packs <= 5'd4;
                    end else if (win) begin
                        frame <= reg_frame(bus.req1_addr, bus.req1_len, bus.req1_data);
                        packs <= reg_packs(bus.req1_len);
                    end else begin
                        frame <= reg_frame(bus.req0_addr, bus.req0_len, bus.req0_data);
                        packs <= reg_packs(bus.req0_len);
                    end
                end
                CSR_WLO: if (!bus.spi_busy) begin
                    cache_vld  <= 1'b1;
                    cache_chan <= cap_chan;
                    frame      <= reg_frame(cap_addr, cap_len, cap_data);
                    packs      <= reg_packs(cap_len);
                end
                REG_WLO: upd_cnt <= '0;
                UPDATE:  upd_cnt <= upd_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ad9958_write_scheduler.sv
// Bench for ad9958_write_scheduler: transaction-level model of arbitration,
// channel cache and frame contents, random shifter latency, plus directed
// scenarios pinned with literal frame values.
module tb_ad9958_write_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ad9958_write_scheduler_if bus();
    ad9958_write_scheduler #(.UPDATE_WIDTH(4), .CSR_MODE_BITS(3'b110)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  packs;
        logic        id;
        bit          csr;
        int          cyc;
    } frame_t;

    logic        v [2];
    logic [1:0]  ch [2];
    logic [4:0]  ad [2];
    logic [1:0]  ln [2];
    logic [31:0] dt [2];
    logic        up [2];
    logic        rdy [2];
    logic        sbusy;
    int          vcyc [2];

    assign bus.req0_valid = v[0];  assign bus.req1_valid = v[1];
    assign bus.req0_chan  = ch[0]; assign bus.req1_chan  = ch[1];
    assign bus.req0_addr  = ad[0]; assign bus.req1_addr  = ad[1];
    assign bus.req0_len   = ln[0]; assign bus.req1_len   = ln[1];
    assign bus.req0_data  = dt[0]; assign bus.req1_data  = dt[1];
    assign bus.req0_update= up[0]; assign bus.req1_update= up[1];
    assign bus.spi_busy   = sbusy;
    assign rdy[0] = bus.req0_ready;
    assign rdy[1] = bus.req1_ready;

    frame_t exp_q[$];
    frame_t log_q[$];
    bit     upd_q[$];
    int     n_cmp = 0, n_bad = 0;
    int     cyc = 0, n_done = 0, busy_fall_cyc = 0, upd_seen = 0;
    bit     m_last = 1'b1, m_cvld = 1'b0, last_csr = 1'b0, stall = 1'b0;
    logic [1:0] m_chan = 2'b00;
    logic   prev_busy = 1'b0;
    logic   mw;
    frame_t mf, ma;
    bit     mu;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    // Expected frame from the byte sequence: byte 0 first, high nibble first.
    function automatic frame_t mk_frame(input bit csr, input logic [1:0] c, input logic [4:0] a,
                                        input logic [1:0] l, input logic [31:0] d, input logic id);
        frame_t     f;
        logic [7:0] b [5];
        logic [3:0] nib;
        int         n, nl;
        f.data = '0; f.id = id; f.csr = csr; f.cyc = 0;
        for (int i = 0; i < 5; i++) b[i] = 8'h00;
        if (csr) begin
            b[1] = {c, 3'b000, 3'b110};
            n = 2;
        end else begin
            nl = (l == 2'd0) ? 4 : int'(l);
            b[0] = {3'b000, a};
            for (int j = 0; j < nl; j++) b[1+j] = 8'(d >> (8 * (nl - 1 - j)));
            n = nl + 1;
        end
        for (int k = 0; k < 2 * n; k++) begin
            nib = (k % 2 == 0) ? b[k/2][7:4] : b[k/2][3:0];
            f.data = f.data | (64'(nib) << (4 * k));
        end
        f.packs = 5'(2 * n);
        return f;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model and per-cycle compare.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete(); upd_q.delete();
            m_last = 1'b1; m_cvld = 1'b0; last_csr = 1'b0; upd_seen = 0;
        end else begin
            if (prev_busy && !bus.spi_busy) busy_fall_cyc = cyc;
            if (bus.req0_ready || bus.req1_ready) begin
                mw = (v[0] && v[1]) ? !m_last : v[1];
                chk("grant", {62'd0, bus.req1_ready, bus.req0_ready}, mw ? 64'd2 : 64'd1);
                chk("busy_in_grant", 64'(bus.busy), 64'd1);
                m_last = mw;
                if (!m_cvld || m_chan != ch[mw]) begin
                    exp_q.push_back(mk_frame(1'b1, ch[mw], ad[mw], ln[mw], dt[mw], mw));
                    m_cvld = 1'b1;
                    m_chan = ch[mw];
                end
                exp_q.push_back(mk_frame(1'b0, ch[mw], ad[mw], ln[mw], dt[mw], mw));
                upd_q.push_back(up[mw]);
            end
            if (bus.spi_trigger) begin
                ma.data = bus.spi_data; ma.packs = bus.spi_packs; ma.id = bus.grant_id;
                ma.cyc = cyc; ma.csr = 1'b0;
                chk("trigger_while_busy", 64'(bus.spi_busy), 64'd0);
                if (exp_q.size() == 0) flag("unexpected_trigger");
                else begin
                    mf = exp_q.pop_front();
                    chk("spi_data", bus.spi_data, mf.data);
                    chk("spi_packs", 64'(bus.spi_packs), 64'(mf.packs));
                    chk("grant_id", 64'(bus.grant_id), 64'(mf.id));
                    if (!mf.csr && last_csr)
                        chk("csr_to_reg_latency", 64'(cyc - busy_fall_cyc), 64'd1);
                    last_csr = mf.csr;
                    ma.csr = mf.csr;
                end
                log_q.push_back(ma);
            end
            if (bus.io_update) upd_seen++;
            if (bus.done) begin
                n_done++;
                if (upd_q.size() == 0) flag("unexpected_done");
                else begin
                    mu = upd_q.pop_front();
                    chk("io_update_cycles", 64'(upd_seen), mu ? 64'd4 : 64'd0);
                    chk("frames_left_at_done", 64'(exp_q.size()), 64'd0);
                end
                upd_seen = 0;
            end
        end
        prev_busy = bus.spi_busy;
    end

    // Shifter model: busy rises 1-4 cycles after a trigger, lasts 1-5 cycles.
    initial begin
        sbusy = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.spi_trigger && !stall && !reset) begin
                repeat ($urandom_range(0, 3) + 1) @(posedge clock);
                #1 sbusy = 1'b1;
                repeat ($urandom_range(1, 5)) @(posedge clock);
                #1 sbusy = 1'b0;
            end
        end
    end

    task automatic issue(input int id, input logic [1:0] c, input logic [4:0] a,
                         input logic [1:0] l, input logic [31:0] d, input logic u);
        ch[id] = c; ad[id] = a; ln[id] = l; dt[id] = d; up[id] = u;
        v[id] = 1'b1; vcyc[id] = cyc;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            if (rdy[id]) begin
                @(posedge clock);
                #1 v[id] = 1'b0;
                return;
            end
        end
        flag("ready_timeout");
        v[id] = 1'b0;
    endtask

    task automatic wait_ndone(input int target);
        for (int t = 0; t < 3000; t++) begin
            if (n_done >= target) return;
            @(negedge clock);
        end
        flag("done_timeout");
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_trigger"}, 64'(bus.spi_trigger), 64'd0);
        chk({nm, "_io_update"}, 64'(bus.io_update), 64'd0);
        chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
        chk({nm, "_done"}, 64'(bus.done), 64'd0);
        chk({nm, "_grant_id"}, 64'(bus.grant_id), 64'd0);
        chk({nm, "_ready"}, {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
        chk({nm, "_spi_data"}, bus.spi_data, 64'd0);
        chk({nm, "_spi_packs"}, 64'(bus.spi_packs), 64'd0);
    endtask

    initial begin
        int s, nd, lsz;
        logic [7:0] cb;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; ch[i] = 0; ad[i] = 0; ln[i] = 0; dt[i] = 0; up[i] = 0;
        end
        repeat (3) @(posedge clock);
        #1 check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // CSR insert, then full 4-byte register write with IO_UPDATE.
        nd = n_done;
        issue(0, 2'b01, 5'h04, 2'd0, 32'h1234_5678, 1'b1);
        wait_ndone(nd + 1);
        chk("t1_frames", 64'(log_q.size()), 64'd2);
        if (log_q.size() >= 2) begin
            chk("t1_csr_data", 64'(log_q[0].data), 64'h6400);
            chk("t1_csr_packs", 64'(log_q[0].packs), 64'd4);
            chk("t1_reg_data", log_q[1].data, 64'h87_6543_2140);
            chk("t1_reg_packs", 64'(log_q[1].packs), 64'd10);
        end

        // Same channel: no CSR, trigger two cycles after valid.
        @(posedge clock); #1;
        nd = n_done;
        issue(0, 2'b01, 5'h05, 2'd1, 32'h0000_00AB, 1'b0);
        wait_ndone(nd + 1);
        chk("t2_frames", 64'(log_q.size()), 64'd3);
        if (log_q.size() >= 3) begin
            chk("t2_reg_data", log_q[2].data, 64'hBA50);
            chk("t2_reg_packs", 64'(log_q[2].packs), 64'd4);
            chk("t2_latency", 64'(log_q[2].cyc - vcyc[0]), 64'd2);
        end

        // Shifter never raises busy: scheduler holds in WHI.
        @(posedge clock); #1;
        stall = 1'b1;
        nd = n_done;
        lsz = log_q.size();
        issue(0, 2'b11, 5'h01, 2'd2, 32'h0000_BEEF, 1'b0);
        for (int t = 0; t < 50 && log_q.size() == lsz; t++) @(negedge clock);
        chk("t5_first_trigger", 64'(log_q.size()), 64'(lsz + 1));
        lsz = log_q.size();
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            chk("t5_busy_held", 64'(bus.busy), 64'd1);
        end
        chk("t5_no_retrigger", 64'(log_q.size()), 64'(lsz));
        @(posedge clock); #1 sbusy = 1'b1;
        repeat (2) @(posedge clock);
        #1 sbusy = 1'b0;
        stall = 1'b0;
        wait_ndone(nd + 1);

        // Alternating channels force a CSR frame before each write.
        s = log_q.size();
        nd = n_done;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            issue(0, (i % 2 == 1) ? 2'b10 : 2'b01, 5'h0A, 2'd3, $urandom, 1'b0);
            wait_ndone(nd + i + 1);
        end
        chk("t4_frames", 64'(log_q.size()), 64'(s + 8));
        for (int i = 0; i < 4 && s + 2 * i < log_q.size(); i++) begin
            cb = {log_q[s+2*i].data[11:8], log_q[s+2*i].data[15:12]};
            chk("t4_csr_byte", 64'(cb), (i % 2 == 1) ? 64'h86 : 64'h46);
            chk("t4_csr_packs", 64'(log_q[s+2*i].packs), 64'd4);
        end

        // Reset in the middle of IO_UPDATE.
        @(posedge clock); #1;
        issue(0, 2'b10, 5'h03, 2'd1, 32'h0000_005A, 1'b1);
        for (int t = 0; t < 200 && !bus.io_update; t++) @(negedge clock);
        chk("t6_in_update", 64'(bus.io_update), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;

        // Both pending from reset: grants alternate starting with req0.
        @(posedge clock); #1;
        s = log_q.size();
        nd = n_done;
        fork
            for (int i = 0; i < 4; i++) issue(0, 2'b01, 5'(5'h10 + i), 2'd1, 32'(i), 1'b0);
            for (int i = 0; i < 4; i++) issue(1, 2'b01, 5'(5'h18 + i), 2'd1, 32'(i), 1'b0);
        join
        wait_ndone(nd + 8);
        chk("t3_frames", 64'(log_q.size()), 64'(s + 9));
        if (log_q.size() >= s + 9) begin
            chk("t3_csr_after_reset", 64'(log_q[s].data), 64'h6400);
            for (int i = 0; i < 8; i++)
                chk("t3_alternate", 64'(log_q[s+1+i].id), 64'(i % 2));
        end

        // Random traffic from both requesters.
        nd = n_done;
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 4)) @(posedge clock);
                #1 issue(0, 2'($urandom), 5'($urandom), 2'($urandom), $urandom, 1'($urandom));
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 4)) @(posedge clock);
                #1 issue(1, 2'($urandom), 5'($urandom), 2'($urandom), $urandom, 1'($urandom));
            end
        join
        wait_ndone(nd + 50);
        repeat (3) @(negedge clock);
        chk("final_idle", 64'(bus.busy), 64'd0);
        chk("final_queue", 64'(exp_q.size() + upd_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
